// File: rtl/video_timing_if.sv
// Raster outputs of video_timing: sync pins, game-space coordinates,
// prefetch requests and the vblank interrupt pulse.
interface video_timing_if;
  logic        hsync_o;
  logic        vsync_o;
  logic        visible_o;
  logic        in_game_o;
  logic [7:0]  display_x_o;
  logic [7:0]  display_y_o;
  logic        prefetch_start_o;
  logic [7:0]  prefetch_y_o;
  logic        vblank_start_o;
  logic [15:0] frame_count_o;

  modport master (
    output hsync_o, vsync_o, visible_o, in_game_o, display_x_o, display_y_o,
           prefetch_start_o, prefetch_y_o, vblank_start_o, frame_count_o
  );

  modport slave (
    input  hsync_o, vsync_o, visible_o, in_game_o, display_x_o, display_y_o,
           prefetch_start_o, prefetch_y_o, vblank_start_o, frame_count_o
  );
endinterface

// File: rtl/video_timing.sv
// VGA 640x480@60 raster generator mapping a 256x240 game area at 2x scale.
// Define VIDEO_TIMING_FRAME_COUNT_EN to enable the 16-bit frame counter.
module video_timing #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int X_OFFSET   = 64,
  parameter int Y_OFFSET   = 0,
  parameter int PREFETCH_H = 0
) (
  input  logic           gpu_clk,
  input  logic           rst,
  video_timing_if.master vt
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  // Line 0 is fetched one game line (two rows) before the window starts.
  localparam int PF0_V    = (Y_OFFSET + V_TOTAL - 2) % V_TOTAL;

  logic [9:0] r_hcount;
  logic [9:0] r_vcount;
  logic       w_h_last;
  logic       w_v_last;

  assign w_h_last = (r_hcount == 10'(H_TOTAL - 1));
  assign w_v_last = (r_vcount == 10'(V_TOTAL - 1));

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_hcount <= 10'd0;
      r_vcount <= 10'd0;
    end else if (w_h_last) begin
      r_hcount <= 10'd0;
      r_vcount <= w_v_last ? 10'd0 : r_vcount + 10'd1;
    end else begin
      r_hcount <= r_hcount + 10'd1;
    end
  end

  logic [9:0] w_hrel;
  logic [9:0] w_vrel;
  logic       w_hsync_n;
  logic       w_vsync_n;
  logic       w_visible;
  logic       w_in_game;
  logic       w_pf_first;
  logic       w_pf_line;
  logic       w_pf_start;
  logic [7:0] w_pf_y;
  logic       w_vblank;

  // Rows/columns before the window wrap to large values, so one unsigned
  // compare covers both edges of the window.
  always_comb begin
    w_hrel     = r_hcount - 10'(X_OFFSET);
    w_vrel     = r_vcount - 10'(Y_OFFSET);
    w_hsync_n  = !((r_hcount >= 10'(HS_START)) && (r_hcount < 10'(HS_END)));
    w_vsync_n  = !((r_vcount >= 10'(VS_START)) && (r_vcount < 10'(VS_END)));
    w_visible  = (r_hcount < 10'(H_VISIBLE)) && (r_vcount < 10'(V_VISIBLE));
    w_in_game  = (w_hrel < 10'd512) && (w_vrel < 10'd480);
    w_pf_first = (r_hcount == 10'(PREFETCH_H)) && (r_vcount == 10'(PF0_V));
    w_pf_line  = (r_hcount == 10'(PREFETCH_H)) && (w_vrel < 10'd478) && !w_vrel[0];
    w_pf_start = w_pf_first || w_pf_line;
    w_pf_y     = w_pf_first ? 8'd0 : w_vrel[8:1] + 8'd1;
    w_vblank   = (r_hcount == 10'd0) && (r_vcount == 10'(V_VISIBLE));
  end

  logic       r_hsync;
  logic       r_vsync;
  logic       r_visible;
  logic       r_in_game;
  logic [7:0] r_display_x;
  logic [7:0] r_display_y;
  logic       r_pf_start;
  logic [7:0] r_pf_y;
  logic       r_vblank;

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_visible   <= 1'b0;
      r_in_game   <= 1'b0;
      r_display_x <= 8'd0;
      r_display_y <= 8'd0;
      r_pf_start  <= 1'b0;
      r_pf_y      <= 8'd0;
      r_vblank    <= 1'b0;
    end else begin
      r_hsync     <= w_hsync_n;
      r_vsync     <= w_vsync_n;
      r_visible   <= w_visible;
      r_in_game   <= w_in_game;
      r_display_x <= w_in_game ? w_hrel[8:1] : 8'd0;
      r_display_y <= w_in_game ? w_vrel[8:1] : 8'd0;
      r_pf_start  <= w_pf_start;
      if (w_pf_start) begin
        r_pf_y <= w_pf_y;
      end
      r_vblank    <= w_vblank;
    end
  end

  assign vt.hsync_o          = r_hsync;
  assign vt.vsync_o          = r_vsync;
  assign vt.visible_o        = r_visible;
  assign vt.in_game_o        = r_in_game;
  assign vt.display_x_o      = r_display_x;
  assign vt.display_y_o      = r_display_y;
  assign vt.prefetch_start_o = r_pf_start;
  assign vt.prefetch_y_o     = r_pf_y;
  assign vt.vblank_start_o   = r_vblank;

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  // Steps on the same decode as the vblank pulse so both outputs move together.
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_frame_count <= 16'd0;
    end else if (w_vblank) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign vt.frame_count_o = r_frame_count;
`else
  assign vt.frame_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench: a default-timing instance plus a horizontally shrunk one
// whose full frames fit in a short run; directed event checks on both.
module tb_video_timing;

  // Shrunk raster: 40 columns per row keeps a frame at 21000 cycles.
  localparam int S_HV = 24, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_XO = 4, S_YO = 3, S_PFH = 3;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vis;
    logic        ing;
    logic [7:0]  dx;
    logic [7:0]  dy;
    logic        pf;
    logic [7:0]  pfy;
    logic        vb;
    logic [15:0] fc;
  } out_t;

  bit   gpu_clk;
  logic rst;

  video_timing_if vt_def ();
  video_timing_if vt_sml ();

  video_timing u_def (
    .gpu_clk (gpu_clk),
    .rst     (rst),
    .vt      (vt_def)
  );

  video_timing #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .X_OFFSET  (S_XO), .Y_OFFSET (S_YO), .PREFETCH_H (S_PFH)
  ) u_sml (
    .gpu_clk (gpu_clk),
    .rst     (rst),
    .vt      (vt_sml)
  );

  always #5 gpu_clk = ~gpu_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      if (n_fail >= 40) finish_run();
    end
  endtask

  function automatic out_t reset_out();
    out_t o;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic out_t model_out(input int h, input int v,
                                     input int hv, input int hf, input int hsw,
                                     input int vv, input int vf, input int vsw, input int vtot,
                                     input int xo, input int yo, input int pfh,
                                     input logic [7:0] pfy_prev, input logic [15:0] fc_prev);
    out_t o;
    int   n;
    o.hs  = !(h >= hv + hf && h < hv + hf + hsw);
    o.vs  = !(v >= vv + vf && v < vv + vf + vsw);
    o.vis = (h < hv) && (v < vv);
    o.ing = (h >= xo) && (h < xo + 512) && (v >= yo) && (v < yo + 480);
    o.dx  = o.ing ? 8'((h - xo) / 2) : 8'd0;
    o.dy  = o.ing ? 8'((v - yo) / 2) : 8'd0;
    n = -1;
    if (h == pfh) begin
      if (v == (yo + vtot - 2) % vtot) n = 0;
      else if (v >= yo && ((v - yo) % 2) == 0 && ((v - yo) / 2 + 1) <= 239) n = (v - yo) / 2 + 1;
    end
    o.pf  = (n >= 0);
    o.pfy = (n >= 0) ? 8'(n) : pfy_prev;
    o.vb  = (h == 0) && (v == vv);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    o.fc  = o.vb ? fc_prev + 16'd1 : fc_prev;
`else
    o.fc  = 16'd0;
`endif
    return o;
  endfunction

  out_t q_def[$];
  out_t q_sml[$];
  bit   was_rst;

  // Reference model: one expected output word per instance per clock edge.
  initial begin
    int md_h = 0, md_v = 0, ms_h = 0, ms_v = 0;
    logic [7:0]  md_pfy = '0, ms_pfy = '0;
    logic [15:0] md_fc = '0, ms_fc = '0;
    out_t ed, es;
    forever begin
      @(posedge gpu_clk);
      if (rst) begin
        ed = reset_out(); es = reset_out();
        md_h = 0; md_v = 0; ms_h = 0; ms_v = 0;
      end else begin
        ed = model_out(md_h, md_v, 640, 16, 96, 480, 10, 2, 525, 64, 0, 0, md_pfy, md_fc);
        es = model_out(ms_h, ms_v, S_HV, S_HF, S_HS, 480, 10, 2, 525, S_XO, S_YO, S_PFH, ms_pfy, ms_fc);
        md_h++;
        if (md_h == 800) begin md_h = 0; md_v = (md_v == 524) ? 0 : md_v + 1; end
        ms_h++;
        if (ms_h == S_HT) begin ms_h = 0; ms_v = (ms_v == 524) ? 0 : ms_v + 1; end
      end
      md_pfy = ed.pfy; md_fc = ed.fc;
      ms_pfy = es.pfy; ms_fc = es.fc;
      q_def.push_back(ed);
      q_sml.push_back(es);
      was_rst = rst;
    end
  end

  int pf_def_cnt = 0;
  int vb_sml_cnt = 0;

  // Output side: pop and compare, plus directed event checks keyed on raster index.
  initial begin
    out_t od, os, pd, ps, e;
    int kd = 0, ks = 0, last_pf_d = -1, last_pf_s = -1, pf_since_vb = 0;
    int hd, vd, hs_i, vs_i;
    pd = reset_out(); ps = reset_out();
    forever begin
      @(negedge gpu_clk);
      od = {vt_def.hsync_o, vt_def.vsync_o, vt_def.visible_o, vt_def.in_game_o,
            vt_def.display_x_o, vt_def.display_y_o, vt_def.prefetch_start_o,
            vt_def.prefetch_y_o, vt_def.vblank_start_o, vt_def.frame_count_o};
      os = {vt_sml.hsync_o, vt_sml.vsync_o, vt_sml.visible_o, vt_sml.in_game_o,
            vt_sml.display_x_o, vt_sml.display_y_o, vt_sml.prefetch_start_o,
            vt_sml.prefetch_y_o, vt_sml.vblank_start_o, vt_sml.frame_count_o};
      if (q_def.size() == 0) check("def_sb_empty", 64'(q_def.size()), 64'd1);
      else begin e = q_def.pop_front(); check("def_out", 64'(od), 64'(e)); end
      if (q_sml.size() == 0) check("sml_sb_empty", 64'(q_sml.size()), 64'd1);
      else begin e = q_sml.pop_front(); check("sml_out", 64'(os), 64'(e)); end

      if (was_rst) begin
        check("rst_def_hs", 64'(od.hs), 64'd1);
        check("rst_def_pf", 64'({od.pf, od.vb}), 64'd0);
        check("rst_sml_fc", 64'(os.fc), 64'd0);
        kd = 0; ks = 0; last_pf_d = -1; last_pf_s = -1;
        pf_def_cnt = 0; pf_since_vb = 0; vb_sml_cnt = 0;
      end else begin
        hd = kd % 800; vd = kd / 800;
        if (kd == 0) begin
          $display("reset released: first output vis=%0d ing=%0d dx=%0d", od.vis, od.ing, od.dx);
          check("first_vis", 64'(od.vis), 64'd1);
          check("first_ing", 64'(od.ing), 64'd0);
          check("first_dx", 64'(od.dx), 64'd0);
        end
        if (pd.hs && !od.hs)   check("def_hs_fall_h", 64'(hd), 64'd656);
        if (!pd.hs && od.hs)   check("def_hs_rise_h", 64'(hd), 64'd752);
        if (!pd.ing && od.ing) check("def_ing_rise_h", 64'(hd), 64'd64);
        if (pd.ing && !od.ing) check("def_ing_fall_h", 64'(hd), 64'd576);
        if (pd.vis && !od.vis) check("def_vis_fall_h", 64'(hd), 64'd640);
        if (hd == 64)  check("def_dx64", 64'(od.dx), 64'd0);
        if (hd == 65)  check("def_dx65", 64'(od.dx), 64'd0);
        if (hd == 66)  check("def_dx66", 64'(od.dx), 64'd1);
        if (hd == 575) check("def_dx575", 64'(od.dx), 64'd255);
        if (od.pf) begin
          check("def_pf_h", 64'(hd), 64'd0);
          check("def_pf_y", 64'(od.pfy), 64'(vd / 2 + 1));
          if (last_pf_d >= 0) check("def_pf_gap", 64'(kd - last_pf_d >= 1600), 64'd1);
          last_pf_d = kd;
          pf_def_cnt++;
        end

        hs_i = ks % S_HT; vs_i = (ks / S_HT) % 525;
        if (!os.vs) check("sml_vs_row", 64'((vs_i == 490) || (vs_i == 491)), 64'd1);
        if (os.pf) begin
          check("sml_pf_h", 64'(hs_i), 64'(S_PFH));
          check("sml_pf_row", 64'(vs_i < 480), 64'd1);
          if (vs_i == 1)   check("sml_pf_y0", 64'(os.pfy), 64'd0);
          if (vs_i == 3)   check("sml_pf_y1", 64'(os.pfy), 64'd1);
          if (vs_i == 479) check("sml_pf_y239", 64'(os.pfy), 64'd239);
          if (last_pf_s >= 0) check("sml_pf_gap", 64'(ks - last_pf_s >= 2 * S_HT), 64'd1);
          last_pf_s = ks;
          pf_since_vb++;
        end
        if (os.vb) begin
          vb_sml_cnt++;
          $display("vblank #%0d at index %0d, prefetches this frame %0d, frame_count %0d",
                   vb_sml_cnt, ks, pf_since_vb, os.fc);
          check("sml_vb_pos", 64'(ks % (S_HT * 525)), 64'(480 * S_HT));
          check("sml_pf_per_frame", 64'(pf_since_vb), 64'd240);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
          check("sml_fc_at_vb", 64'(os.fc), 64'(vb_sml_cnt));
`else
          check("sml_fc_at_vb", 64'(os.fc), 64'd0);
`endif
          pf_since_vb = 0;
        end
        kd++; ks++;
      end
      pd = od; ps = os;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (5) @(negedge gpu_clk);
    rst = 1'b0;
    repeat (200 * S_HT + 30) @(negedge gpu_clk);
    $display("mid-frame reset applied");
    rst = 1'b1;
    @(negedge gpu_clk);
    rst = 1'b0;
    repeat (45000) @(negedge gpu_clk);
    #1;
    check("def_pf_total", 64'(pf_def_cnt), 64'd29);
    check("sml_vb_total", 64'(vb_sml_cnt), 64'd2);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    check("sml_fc_end", 64'(vt_sml.frame_count_o), 64'd2);
`else
    check("sml_fc_end", 64'(vt_sml.frame_count_o), 64'd0);
`endif
    finish_run();
  end

endmodule
